issue_queue: RTL
================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameters: DEPTH, default 4, entry count; TAG_W, default 6, physical-register tag width; ROB_W, default 5, ROB index width; OP_W, default 5, micro-op code width.
REQ-002 clk  in  1  clock, rising-edge.
REQ-003 rstn  in  1  reset; asynchronous, active-low.
REQ-004 flush  in  1  synchronous squash of all entries.
REQ-005 in_valid  in  1  ID/EX register holds a valid micro-op.
REQ-006 in_ready  out  1  queue accepts a micro-op this cycle.
REQ-007 in_op  in  OP_W; in_imm  in  32; in_rob_idx  in  ROB_W; in_rd_tag  in  TAG_W  payload fields.
REQ-008 in_rs1_tag, in_rs2_tag  in  TAG_W each; in_rs1_rdy, in_rs2_rdy  in  1 each  source tag and source-available flag.
REQ-009 cdb_valid  in  1; cdb_tag  in  TAG_W  result broadcast (wakeup).
REQ-010 issue_valid  out  1  a fully-ready entry is offered to EX.
REQ-011 issue_ready  in  1  EX accepts the offered entry.
REQ-012 issue_op, issue_imm, issue_rob_idx, issue_rd_tag, issue_rs1_tag, issue_rs2_tag  out  field widths as inputs  offered payload.
REQ-013 count  out  clog2(DEPTH+1)  number of occupied entries.

Function
REQ-014 Storage is a collapsing queue; entry 0 is the oldest, occupied entries are contiguous from index 0.
REQ-015 Entry holds valid, op, imm, rob_idx, rd_tag, rs1_tag, rs1_rdy, rs2_tag, rs2_rdy.
REQ-016 in_ready = (count < DEPTH) and not flush; it does not account for a same-cycle issue.
REQ-017 Accept = in_valid and in_ready; the accepted micro-op is written at the first free index after this cycle's compaction.
REQ-018 issue_valid = not flush and at least one occupied entry has rs1_rdy and rs2_rdy both set; the offered entry is the lowest-index such entry.
REQ-019 issue_* outputs are combinational from registered state; an entry woken at edge N is eligible from cycle N+1 onward.
REQ-020 Fire = issue_valid and issue_ready; at the clock edge, the fired entry is removed and all higher-index entries shift down by one, keeping their order.
REQ-021 While issue_valid is high and issue_ready is low, the offered entry and its payload stay stable until fire, unless an older entry becomes ready first.
REQ-022 Wakeup: when cdb_valid is high, every occupied entry with rsX_tag == cdb_tag sets rsX_rdy at the edge; an already-set flag stays set.
REQ-023 Wakeup bypass: an accepted micro-op whose rsX_tag == cdb_tag with cdb_valid high is stored with rsX_rdy = 1.
REQ-024 Wakeup also applies to entries that shift position in the same cycle.
REQ-025 Simultaneous accept and fire with count == k: new entry lands at index k-1 and count is unchanged.
REQ-026 Accept without fire increments count; fire without accept decrements count; count saturates at neither end beyond 0..DEPTH.
REQ-027 Flush: at the edge all valid bits clear and count becomes 0; accept and fire are both suppressed that cycle.
REQ-028 Tag 0 gets no special treatment; the source-available flags alone determine readiness.

Reset
REQ-029 On rstn low, immediately: all valid bits 0, count 0, issue_valid 0, in_ready 1.
REQ-030 Payload registers need no reset; issue_* payload is don't-care while issue_valid is 0.
REQ-031 An in-flight accept or fire coincident with reset assertion is discarded; no entry survives reset.

Verification
REQ-032 Reset, then accept op A (rs1_rdy=1, rs2_rdy=1, rob 3) -> next cycle issue_valid=1, issue_rob_idx=3, count=1; issue_ready=1 -> count=0.
REQ-033 Fill 4 not-ready entries -> in_ready=0, count=4; CDB tag matching entry 2 only -> entry 2 issues next cycle; after fire, entries 0,1,3 remain in order and count=3.
REQ-034 Two ready entries at indices 1 and 3, issue_ready=0 for 3 cycles -> index 1 is held stable; issue_ready=1 -> index 1 fires first, then index 3's micro-op.
REQ-035 Accept with rs2_tag=9, rs2_rdy=0 while cdb_valid=1, cdb_tag=9 -> stored ready; issue_valid=1 next cycle.
REQ-036 count=4, in_valid=1, fire same cycle -> in_ready=0 so no accept, count=3; next cycle accept plus fire -> count stays 3.
REQ-037 Three entries, flush=1 with in_valid=1 and issue_ready=1 -> no accept, no fire; count=0 and issue_valid=0 after the edge.

Source files
------------

// File: rtl/issue_queue.sv
// Collapsing issue queue: oldest entry at index 0. Offers the oldest fully-ready micro-op to EX,
// wakes sources from the CDB and compacts on issue.
module issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned ROB_W = 5,
    parameter int unsigned OP_W  = 5
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              in_op,
    input  logic [31:0]                  in_imm,
    input  logic [ROB_W-1:0]             in_rob_idx,
    input  logic [TAG_W-1:0]             in_rd_tag,
    input  logic [TAG_W-1:0]             in_rs1_tag,
    input  logic [TAG_W-1:0]             in_rs2_tag,
    input  logic                         in_rs1_rdy,
    input  logic                         in_rs2_rdy,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [OP_W-1:0]              issue_op,
    output logic [31:0]                  issue_imm,
    output logic [ROB_W-1:0]             issue_rob_idx,
    output logic [TAG_W-1:0]             issue_rd_tag,
    output logic [TAG_W-1:0]             issue_rs1_tag,
    output logic [TAG_W-1:0]             issue_rs2_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [31:0]      imm;
        logic [ROB_W-1:0] rob_idx;
        logic [TAG_W-1:0] rd_tag;
        logic [TAG_W-1:0] rs1_tag;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs2_rdy;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    entry_t             woken [DEPTH];
    entry_t             in_ent;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   sel;
    logic               any_rdy;
    logic               accept, fire;

    // Oldest-first select: scan downward so the lowest ready index wins.
    always_comb begin
        sel     = '0;
        any_rdy = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel     = IDX_W'(i);
                any_rdy = 1'b1;
            end
        end
    end

    assign in_ready      = (count_q < CNT_W'(DEPTH)) && !flush;
    assign issue_valid   = any_rdy && !flush;
    assign accept        = in_valid && in_ready;
    assign fire          = issue_valid && issue_ready;
    assign count         = count_q;
    assign issue_op      = ent_q[sel].op;
    assign issue_imm     = ent_q[sel].imm;
    assign issue_rob_idx = ent_q[sel].rob_idx;
    assign issue_rd_tag  = ent_q[sel].rd_tag;
    assign issue_rs1_tag = ent_q[sel].rs1_tag;
    assign issue_rs2_tag = ent_q[sel].rs2_tag;

    // Wakeup is applied before the shift so moving entries are woken too.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i]         = ent_q[i];
            woken[i].rs1_rdy = ent_q[i].rs1_rdy || (cdb_valid && ent_q[i].rs1_tag == cdb_tag);
            woken[i].rs2_rdy = ent_q[i].rs2_rdy || (cdb_valid && ent_q[i].rs2_tag == cdb_tag);
        end
        in_ent.op      = in_op;
        in_ent.imm     = in_imm;
        in_ent.rob_idx = in_rob_idx;
        in_ent.rd_tag  = in_rd_tag;
        in_ent.rs1_tag = in_rs1_tag;
        in_ent.rs1_rdy = in_rs1_rdy || (cdb_valid && in_rs1_tag == cdb_tag);
        in_ent.rs2_tag = in_rs2_tag;
        in_ent.rs2_rdy = in_rs2_rdy || (cdb_valid && in_rs2_tag == cdb_tag);
    end

    always_comb begin
        ent_d   = woken;
        valid_d = valid_q;
        wr_idx  = count_q - CNT_W'(fire);
        if (fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel) begin
                    ent_d[i]   = woken[i+1];
                    valid_d[i] = valid_q[i+1];
                end
            end
            valid_d[DEPTH-1] = 1'b0;
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    ent_d[i]   = in_ent;
                    valid_d[i] = 1'b1;
                end
            end
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(fire);
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

endmodule
